e203_ifu_litebpu_jx: RTL

Static branch-prediction unit in the IFU, consuming the mini-decoder's branch/jump info bus (dec_jal, dec_jalr, dec_bxx, dec_bjp_imm, dec_jalr_rs1idx) for the instruction being fetched.
- Outputs the predicted-taken flag and the two operands of the IFU next-PC adder.
- For JALR, obtains rs1 in one of three ways:
  - x0: constant zero.
  - x1: dedicated regfile tap.
  - xn: borrows the shared regfile rs1 read port for one cycle, stalling fetch via bpu_wait.

---
 rtl/e203_ifu_litebpu_jx_pkg.sv | 10 +
 rtl/e203_ifu_litebpu_jx_if.sv | 26 ++
 rtl/e203_ifu_litebpu_jx_dfflr.sv | 15 +
 rtl/e203_ifu_litebpu_jx.sv | 64 ++++++
 4 files changed

// File: rtl/e203_ifu_litebpu_jx_pkg.sv
// e203_ifu_litebpu_jx_pkg: shared widths and FSM state type for the lite branch-prediction unit.
package e203_ifu_litebpu_jx_pkg;
    localparam int E203_XLEN        = 32;
    localparam int E203_PC_SIZE     = 32;
    localparam int E203_RFIDX_WIDTH = 5;
    typedef enum logic {
        IDLE = 1'b0,
        RDRF = 1'b1
    } bpu_state_e;
endpackage

// File: rtl/e203_ifu_litebpu_jx_if.sv
// e203_ifu_litebpu_jx_if: mini-decoder branch info bus plus the prediction returned to the IFU.
interface e203_ifu_litebpu_jx_if #(
    parameter int XLEN    = 32,
    parameter int PC_SIZE = 32,
    parameter int RFIDX_W = 5
);
    logic [PC_SIZE-1:0] pc;
    logic               dec_i_valid;
    logic               dec_jal;
    logic               dec_jalr;
    logic               dec_bxx;
    logic [XLEN-1:0]    dec_bjp_imm;
    logic [RFIDX_W-1:0] dec_jalr_rs1idx;
    logic               bpu_wait;
    logic               prdt_taken;
    logic [PC_SIZE-1:0] prdt_pc_add_op1;
    logic [PC_SIZE-1:0] prdt_pc_add_op2;
    modport master (
        output pc, dec_i_valid, dec_jal, dec_jalr, dec_bxx, dec_bjp_imm, dec_jalr_rs1idx,
        input  bpu_wait, prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2
    );
    modport slave (
        input  pc, dec_i_valid, dec_jal, dec_jalr, dec_bxx, dec_bjp_imm, dec_jalr_rs1idx,
        output bpu_wait, prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2
    );
endinterface

// File: rtl/e203_ifu_litebpu_jx_dfflr.sv
// e203_ifu_litebpu_jx_dfflr: load-enabled flop with asynchronous active-low reset to zero.
module e203_ifu_litebpu_jx_dfflr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) qout <= '0;
        else if (lden) qout <= dnxt;
    end
endmodule

// File: rtl/e203_ifu_litebpu_jx.sv
// e203_ifu_litebpu_jx: static BTFN predictor producing the next-PC adder operands;
// JALR rs1 comes from zero, the x1 tap, or a one-cycle borrow of the shared rs1 read port.
module e203_ifu_litebpu_jx
    import e203_ifu_litebpu_jx_pkg::*;
#(
    parameter int XLEN    = E203_XLEN,
    parameter int PC_SIZE = E203_PC_SIZE,
    parameter int RFIDX_W = E203_RFIDX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    e203_ifu_litebpu_jx_if.slave  dec,
    input  logic                  oitf_empty,
    input  logic                  ir_empty,
    input  logic                  ir_rs1en,
    input  logic                  jalr_rs1idx_cam_irrdidx,
    input  logic                  ir_valid_clr,
    input  logic [XLEN-1:0]       rf2bpu_x1,
    input  logic [XLEN-1:0]       rf2bpu_rs1,
    output logic                  bpu2rf_rs1_ena
);
    logic       rs1x0, rs1x1, rs1xn, jalr_v;
    logic       x1_dep, xn_dep, rdrf_set, rs1_blk, idle;
    logic [0:0] state_q;
    bpu_state_e state, nxt_state;

    assign rs1x0  = dec.dec_jalr_rs1idx == '0;
    assign rs1x1  = dec.dec_jalr_rs1idx == RFIDX_W'(1);
    assign rs1xn  = ~rs1x0 & ~rs1x1;
    assign jalr_v = dec.dec_i_valid & dec.dec_jalr;

    assign dec.prdt_taken      = dec.dec_jal | dec.dec_jalr | (dec.dec_bxx & dec.dec_bjp_imm[XLEN-1]);
    assign dec.prdt_pc_add_op2 = PC_SIZE'(dec.dec_bjp_imm);
    assign dec.prdt_pc_add_op1 = (dec.dec_bxx | dec.dec_jal | ~dec.dec_jalr) ? dec.pc
                               : rs1x0 ? '0
                               : rs1x1 ? PC_SIZE'(rf2bpu_x1)
                               : PC_SIZE'(rf2bpu_rs1);

    // An IR instruction leaving this cycle with no OITF entries no longer blocks the read
    assign x1_dep = jalr_v & rs1x1 & (~oitf_empty | jalr_rs1idx_cam_irrdidx);
    assign xn_dep = jalr_v & rs1xn & (~oitf_empty | (~ir_empty & ~ir_valid_clr));

    assign state    = bpu_state_e'(state_q);
    assign idle     = state == IDLE;
    assign rdrf_set = idle & jalr_v & rs1xn & ~xn_dep & ~ir_rs1en;
    assign rs1_blk  = idle & jalr_v & rs1xn & ir_rs1en;

    always_comb begin
        nxt_state = IDLE;
        nxt_state = (idle & rdrf_set) ? RDRF : IDLE;
    end

    e203_ifu_litebpu_jx_dfflr #(.DW(1)) u_rdrf (
        .clk  (clk),
        .rst_n(rst_n),
        .lden (rdrf_set | ~idle),
        .dnxt (nxt_state),
        .qout (state_q)
    );

    // Wait drops in RDRF so the IFU captures the target while the port data is valid
    assign bpu2rf_rs1_ena = state == RDRF;
    assign dec.bpu_wait   = x1_dep | (idle & xn_dep) | rdrf_set | rs1_blk;
endmodule
